fetch: RTL and testbench

Front-end fetch stage that produces the `valid_fe1` / `instr_fe1` stream consumed by decode, honouring decode's `stall` backpressure. It generates sequential PCs, issues word reads to instruction memory under a credit limit, and buffers returned words in a small instruction queue. On a branch redirect it flushes the queue and discards stale in-flight responses.

---
 rtl/instr_pkg.sv | 23 ++
 rtl/fetch_if.sv | 24 ++
 rtl/fetch_iq.sv | 102 ++++++++++
 rtl/fetch.sv | 111 +++++++++++
 tb/tb_fetch.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared instruction packet types for the front end.
// The fetch queue entry carries its own reserved/valid tracking beside the packet.
package instr_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
`ifdef SIMULATION
    logic [31:0] SIMID;
`endif
  } t_instr_pkt;

  typedef struct packed {
    logic       reserved;
    logic       valid;
    t_instr_pkt pkt;
  } t_fetch_iq_entry;

  function automatic logic [31:0] next_fetch_pc(logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_iq.sv
// Circular instruction queue: slots are reserved at the tail when a request issues,
// filled in request order as responses return, and popped from the head.
module fetch_iq
  import instr_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       reserve,
  input  logic [31:0]                reserve_pc,
  input  logic                       fill,
  input  t_instr_pkt                 fill_pkt,
  input  logic                       pop,
  output logic [$clog2(Depth+1)-1:0] count,
  output t_instr_pkt                 head_pkt
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  t_fetch_iq_entry [Depth-1:0] entries_q, entries_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  // count: filled entries; used: filled plus reserved-but-unfilled
  logic [CntW-1:0] count_q, count_d, used_q, used_d;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fill_d    = fill_q;
    count_d   = count_q;
    used_d    = used_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      used_d  = '0;
      for (int i = 0; i < int'(Depth); i++) begin
        entries_d[PtrW'(i)].reserved = 1'b0;
        entries_d[PtrW'(i)].valid    = 1'b0;
      end
    end else begin
      if (pop) begin
        entries_d[head_q].reserved = 1'b0;
        entries_d[head_q].valid    = 1'b0;
        head_d                     = head_q + PtrW'(1);
      end
      // A reserve on a full queue with a pop reuses the slot just vacated
      if (reserve) begin
        entries_d[tail_q].reserved = 1'b1;
        entries_d[tail_q].valid    = 1'b0;
        entries_d[tail_q].pkt      = '0;
        entries_d[tail_q].pkt.pc   = reserve_pc;
        tail_d                     = tail_q + PtrW'(1);
      end
      if (fill) begin
        entries_d[fill_q].valid     = 1'b1;
        entries_d[fill_q].pkt.instr = fill_pkt.instr;
`ifdef SIMULATION
        entries_d[fill_q].pkt.SIMID = fill_pkt.SIMID;
`endif
        fill_d = fill_q + PtrW'(1);
      end
      count_d = count_q + CntW'(fill) - CntW'(pop);
      used_d  = used_q + CntW'(reserve) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      used_q    <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      used_q    <= used_d;
    end
  end

  assign count    = count_q;
  assign head_pkt = entries_q[head_q].pkt;

`ifndef SYNTHESIS
  a_fill_has_slot: assert property (@(posedge clk) disable iff (reset)
      !(fill && !flush && count_q == used_q))
    else $error("fetch_iq: push with no reserved slot");
  a_reserve_not_full: assert property (@(posedge clk) disable iff (reset)
      !(reserve && !flush && !pop && used_q == CntW'(Depth)))
    else $error("fetch_iq: reserve on full queue");
`endif

endmodule

// File: rtl/fetch.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, stale-response
// dropping after redirects, and an instruction queue feeding decode.
module fetch
  import instr_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IQ_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  fetch_if.master      imem,
  input  logic         stall,
  output logic         valid_fe1,
  output t_instr_pkt   instr_fe1
);

  localparam int unsigned CntW = $clog2(IQ_DEPTH + 1);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  // outstanding counts every request in flight, including ones already marked for dropping
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] iq_count;
  logic [CntW:0]   credit_used;
  logic            req_fire, rsp_drop, rsp_push, pop;
  t_instr_pkt      fill_pkt, head_pkt;

  assign credit_used         = {1'b0, iq_count} + {1'b0, outstanding_q};
  assign imem.imem_req_valid = ~reset & ~redirect_valid & (credit_used < (CntW+1)'(IQ_DEPTH));
  assign imem.imem_req_addr  = fetch_pc_q;

  assign req_fire = imem.imem_req_valid & imem.imem_req_ready;
  assign rsp_drop = imem.imem_rsp_valid & (drop_cnt_q != '0);
  assign rsp_push = imem.imem_rsp_valid & (drop_cnt_q == '0) & ~redirect_valid;
  assign pop      = valid_fe1 & ~stall & ~redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem.imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q - CntW'(rsp_drop);
    if (req_fire) begin
      fetch_pc_d = next_fetch_pc(fetch_pc_q);
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      // Every response still to come belongs to the old path
      drop_cnt_d = outstanding_q - CntW'(imem.imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef SIMULATION
  logic [31:0] simid_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      simid_q <= '0;
    end else if (rsp_push) begin
      simid_q <= simid_q + 32'd1;
    end
  end
`endif

  always_comb begin
    fill_pkt       = '0;
    fill_pkt.instr = imem.imem_rsp_data;
`ifdef SIMULATION
    fill_pkt.SIMID = simid_q;
`endif
  end

  fetch_iq #(
    .Depth (IQ_DEPTH)
  ) u_iq (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .reserve    (req_fire),
    .reserve_pc (fetch_pc_q),
    .fill       (rsp_push),
    .fill_pkt   (fill_pkt),
    .pop        (pop),
    .count      (iq_count),
    .head_pkt   (head_pkt)
  );

  assign valid_fe1 = iq_count != '0;
  assign instr_fe1 = valid_fe1 ? head_pkt : '0;

`ifdef SIMULATION
  always @(posedge clk) begin
    if (!reset && pop) begin
      $display("INFO: fetch deliver pc=%h instr=%h simid=%0d",
               instr_fe1.pc, instr_fe1.instr, instr_fe1.SIMID);
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: an in-bench memory plus a queue-level model of the
// fetch stage, compared every cycle, with hand-computed literals for key scenarios.
module tb_fetch;
  import instr_pkg::*;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        valid_fe1;
  t_instr_pkt  instr_fe1;

  fetch_if imem_bus ();

  fetch #(
    .RESET_PC (32'h0000_0000),
    .IQ_DEPTH (Depth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .stall          (stall),
    .valid_fe1      (valid_fe1),
    .instr_fe1      (instr_fe1)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit stale; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } pkt_t;

  mreq_t   mem_q[$];
  flight_t fl_q[$];
  pkt_t    iq_q[$];
  logic [31:0] m_pc = 32'h0;
  int cyc = 0;
  int lat = 1;
  int n_pass = 0;
  int n_total = 0;

  logic        s_rv, s_vfe;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // One clock cycle: called at posedge+1 with this cycle's inputs set; returns at next posedge+1
  task automatic cycle();
    logic        exp_rv, fire, rsp;
    logic [31:0] rdata;
    flight_t     f;
    rsp   = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    rdata = rsp ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
    imem_bus.imem_rsp_valid = rsp;
    imem_bus.imem_rsp_data  = rdata;
    #4;
    s_rv    = imem_bus.imem_req_valid;
    s_addr  = imem_bus.imem_req_addr;
    s_vfe   = valid_fe1;
    s_pc    = instr_fe1.pc;
    s_instr = instr_fe1.instr;
    exp_rv  = !reset && !redirect_valid && (iq_q.size() + fl_q.size() < Depth);
    check($sformatf("c%0d req_valid", cyc), 32'(s_rv), 32'(exp_rv));
    if (exp_rv) check($sformatf("c%0d req_addr", cyc), s_addr, m_pc);
    check($sformatf("c%0d valid_fe1", cyc), 32'(s_vfe), 32'(iq_q.size() != 0));
    if (iq_q.size() != 0) begin
      check($sformatf("c%0d fe1_pc", cyc), s_pc, iq_q[0].pc);
      check($sformatf("c%0d fe1_instr", cyc), s_instr, iq_q[0].instr);
    end else begin
      check($sformatf("c%0d fe1_zero", cyc), s_pc | s_instr, 32'h0);
    end
    fire = exp_rv && imem_bus.imem_req_ready;
    if (reset) begin
      mem_q.delete();
      fl_q.delete();
      iq_q.delete();
      m_pc = 32'h0;
    end else if (redirect_valid) begin
      if (rsp) begin
        void'(mem_q.pop_front());
        void'(fl_q.pop_front());
      end
      iq_q.delete();
      foreach (fl_q[i]) fl_q[i].stale = 1'b1;
      m_pc = redirect_pc;
    end else begin
      if (iq_q.size() != 0 && !stall) void'(iq_q.pop_front());
      if (fire) begin
        mem_q.push_back('{addr: m_pc, due: cyc + lat});
        fl_q.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (rsp) begin
        void'(mem_q.pop_front());
        f = fl_q.pop_front();
        if (!f.stale) iq_q.push_back('{pc: f.pc, instr: rdata});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int first_v;
    int fires;
    logic [31:0] pcs [5];
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    stall = 1'b0;
    imem_bus.imem_req_ready = 1'b1;
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = 32'h0;
    @(posedge clk);
    #1;

    // Reset values and release with latency 1
    do_reset();
    check("rst req_valid", 32'(s_rv), 32'h0);
    check("rst valid_fe1", 32'(s_vfe), 32'h0);
    check("rst instr_fe1", s_pc | s_instr, 32'h0);
    lat = 1;
    cycle();
    check("first req_valid", 32'(s_rv), 32'h1);
    check("first req_addr", s_addr, 32'h0);
    check("c0 valid_fe1", 32'(s_vfe), 32'h0);
    first_v = -1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      pcs[k] = s_pc;
      if (s_vfe && first_v < 0) first_v = k;
    end
    check("first valid latency", 32'(first_v), 32'd2);
    check("deliver pc0", pcs[2], 32'h0);
    check("deliver pc1", pcs[3], 32'h4);
    check("deliver pc2", pcs[4], 32'h8);

    // Stall for 5 cycles
    stall = 1'b1;
    fires = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (s_rv && imem_bus.imem_req_ready) fires++;
      check("stall head pc", s_pc, 32'hC);
      check("stall head instr", s_instr, 32'hFFF3_000C);
    end
    check("stall fires", 32'(fires), 32'd2);
    check("stall req_valid low", 32'(s_rv), 32'h0);
    stall = 1'b0;
    for (int k = 0; k < 6; k++) cycle();

    // Redirect with 3 requests in flight, no coincident response
    do_reset();
    lat = 4;
    for (int k = 0; k < 3; k++) cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check("redir valid_fe1", 32'(s_vfe), 32'h0);
    check("redir req_valid", 32'(s_rv), 32'h1);
    check("redir req_addr", s_addr, 32'h100);
    first_v = -1;
    for (int j = 0; j < 12 && first_v < 0; j++) begin
      cycle();
      if (s_vfe) begin
        first_v = j;
        check("redir first pc", s_pc, 32'h100);
        check("redir first instr", s_instr, 32'hFEFF_0100);
      end
    end
    check("redir first valid cycle", 32'(first_v), 32'd4);
    for (int k = 0; k < 6; k++) cycle();

    // Redirect coincident with a response
    do_reset();
    lat = 3;
    for (int k = 0; k < 3; k++) cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    check("coinc drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    cycle();
    check("coinc word dropped", 32'(s_vfe), 32'h0);
    first_v = -1;
    for (int j = 0; j < 12 && first_v < 0; j++) begin
      cycle();
      if (s_vfe) begin
        first_v = j;
        check("coinc first pc", s_pc, 32'h200);
        check("coinc first instr", s_instr, 32'hFDFF_0200);
      end
    end
    check("coinc delivered", 32'(first_v >= 0), 32'h1);

    // Memory not ready for 4 cycles
    do_reset();
    lat = 1;
    imem_bus.imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("noready req_valid", 32'(s_rv), 32'h1);
      check("noready addr", s_addr, 32'h0);
    end
    imem_bus.imem_req_ready = 1'b1;
    cycle();
    cycle();
    check("ready resume addr", s_addr, 32'h4);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check("wrap req_addr0", s_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap req_valid", 32'(s_rv), 32'h1);
    check("wrap req_addr1", s_addr, 32'h0);
    for (int k = 0; k < 4; k++) cycle();

    // Mixed traffic with stalls, backpressure, a redirect and a mid-run reset
    do_reset();
    lat = 2;
    for (int i = 0; i < 60; i++) begin
      stall = (i % 5 == 2) || (i % 11 == 7);
      imem_bus.imem_req_ready = (i % 7 != 3);
      redirect_valid = (i == 30);
      redirect_pc = 32'h40;
      reset = (i == 45);
      cycle();
    end
    redirect_valid = 1'b0;
    reset = 1'b0;
    stall = 1'b0;
    imem_bus.imem_req_ready = 1'b1;
    for (int k = 0; k < 10; k++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
